rr_rsp_router: RTL and testbench

// - Return-path partner of the 4-way round-robin request arbiter.
// - Records the one-hot grant of every request issued to the shared resource in an in-order tag FIFO.
// - Routes each in-order response from the shared resource back to the requester that issued it.
// - Sits between the shared resource's response port and the requesters' response inputs.
// - Provides back-pressure on both the issue side and the response side.

---
 rtl/rr_rsp_router.sv | 172 +++++++++++++++++
 tb/tb_rr_rsp_router.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_rsp_router.sv
// rr_rsp_router: return path for the 4-way round-robin arbiter.
// Each request issued to the shared resource pushes its requester index into an
// in-order tag FIFO. Each in-order response pops the head tag and is steered,
// through one registered output stage, back to that requester.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_vld/gnt/rdy     issue side: one-hot grant of each accepted request
//   rsp_vld/data/rdy      response side from the shared resource
//   out_vld/data/rdy      per-requester one-hot valid, shared payload, per-requester ready
//   outstanding           tag FIFO occupancy (output stage not counted)
//   err                   sticky error: overflow, bad grant, response with no tag, timeout
//   timeout               sticky watchdog flag (only with RR_RSP_TIMEOUT_EN)
// Optional feature macro: RR_RSP_TIMEOUT_EN adds the response watchdog and the timeout port.
module rr_rsp_router #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_vld,
    input  logic [NUM_REQ-1:0]       issue_gnt,
    output logic                     issue_rdy,
    input  logic                     rsp_vld,
    input  logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_rdy,
    output logic [NUM_REQ-1:0]       out_vld,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NUM_REQ-1:0]       out_rdy,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err
`ifdef RR_RSP_TIMEOUT_EN
    ,
    output logic                     timeout
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0]     tag_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              stage_vld;
    logic [IW-1:0]     stage_idx;
    logic [DATA_W-1:0] stage_data;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              gnt_onehot;
    logic [IW-1:0]     gnt_idx;
    logic              err_set;
    logic              to_hit;

    // Lowest set bit of the grant; an all-zero grant encodes index 0.
    always_comb begin
        gnt_idx    = '0;
        gnt_onehot = (issue_gnt != '0) &&
                     ((issue_gnt & (issue_gnt - NUM_REQ'(1))) == '0);
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (issue_gnt[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

    // Pointer-based occupancy; extra MSB distinguishes full from empty.
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign outstanding = wr_ptr - rd_ptr;

    // No pass-through: issue_rdy ignores a same-cycle pop, responses ignore a same-cycle push.
    assign issue_rdy = !full;
    assign rsp_rdy   = !empty && (!stage_vld || out_rdy[stage_idx]);
    assign push      = issue_vld && !full;
    assign pop       = rsp_vld && rsp_rdy;

    // Output stage decoded to a one-hot valid.
    always_comb begin
        out_vld = '0;
        if (stage_vld) begin
            out_vld[stage_idx] = 1'b1;
        end
    end
    assign out_data = stage_data;

    assign err_set = (issue_vld && full) ||
                     (issue_vld && !gnt_onehot) ||
                     (rsp_vld && empty) ||
                     to_hit;

    // Tag FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr[AW-1:0]] <= gnt_idx;
                wr_ptr                  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Output stage: load on accept (even while draining), otherwise clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld  <= 1'b0;
            stage_idx  <= '0;
            stage_data <= '0;
        end else if (pop) begin
            stage_vld  <= 1'b1;
            stage_idx  <= tag_mem[rd_ptr[AW-1:0]];
            stage_data <= rsp_data;
        end else if (stage_vld && out_rdy[stage_idx]) begin
            stage_vld  <= 1'b0;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

`ifdef RR_RSP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic [CW-1:0] to_cnt_nxt;

    // Watchdog age: cleared while idle or on progress, saturates at the limit.
    always_comb begin
        to_cnt_nxt = to_cnt;
        if (empty || pop) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != CW'(TIMEOUT)) begin
            to_cnt_nxt = to_cnt + CW'(1);
        end
    end
    assign to_hit = (to_cnt_nxt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (to_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
    wire unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_rr_rsp_router.sv
module tb_rr_rsp_router;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TMO     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 issue_vld = 1'b0;
    logic [NUM_REQ-1:0]   issue_gnt = '0;
    logic                 issue_rdy;
    logic                 rsp_vld = 1'b0;
    logic [DATA_W-1:0]    rsp_data = '0;
    logic                 rsp_rdy;
    logic [NUM_REQ-1:0]   out_vld;
    logic [DATA_W-1:0]    out_data;
    logic [NUM_REQ-1:0]   out_rdy = '1;
    logic [3:0]           outstanding;
    logic                 err;
`ifdef RR_RSP_TIMEOUT_EN
    logic                 timeout;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    rr_rsp_router #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_vld   (issue_vld),
        .issue_gnt   (issue_gnt),
        .issue_rdy   (issue_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rsp_rdy     (rsp_rdy),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
        .outstanding (outstanding),
        .err         (err)
`ifdef RR_RSP_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned        tag_q[$];
    logic               m_vld;
    int unsigned        m_idx;
    logic [DATA_W-1:0]  m_data;
    logic               m_err;
    int unsigned        m_age;
    logic               m_to;

    function automatic int unsigned low_bit(input logic [NUM_REQ-1:0] g);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic exp_rsp_rdy();
        return (tag_q.size() != 0) && (!m_vld || out_rdy[m_idx]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q.delete();
            m_vld  <= 1'b0;
            m_idx  <= 0;
            m_data <= '0;
            m_err  <= 1'b0;
            m_age  <= 0;
            m_to   <= 1'b0;
        end else begin
            logic acc;
            logic full_now;
            logic bad;
            int unsigned age_n;
            acc      = rsp_vld && exp_rsp_rdy();
            full_now = (tag_q.size() == DEPTH);
            bad      = (issue_vld && full_now) ||
                       (issue_vld && !$onehot(issue_gnt)) ||
                       (rsp_vld && tag_q.size() == 0);
            if (tag_q.size() == 0 || acc) age_n = 0;
            else if (m_age < TMO)         age_n = m_age + 1;
            else                          age_n = m_age;
            m_age <= age_n;
`ifdef RR_RSP_TIMEOUT_EN
            if (age_n == TMO) begin
                m_to <= 1'b1;
                bad = 1'b1;
            end
`endif
            if (bad) m_err <= 1'b1;
            if (acc) begin
                m_vld  <= 1'b1;
                m_idx  <= tag_q[0];
                m_data <= rsp_data;
                void'(tag_q.pop_front());
            end else if (m_vld && out_rdy[m_idx]) begin
                m_vld <= 1'b0;
            end
            if (issue_vld && !full_now) tag_q.push_back(low_bit(issue_gnt));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [NUM_REQ-1:0] ev;
            ev = '0;
            if (m_vld) ev[m_idx] = 1'b1;
            chk("issue_rdy", 64'(issue_rdy), 64'(tag_q.size() != DEPTH));
            chk("rsp_rdy", 64'(rsp_rdy), 64'(exp_rsp_rdy()));
            chk("out_vld", 64'(out_vld), 64'(ev));
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("outstanding", 64'(outstanding), 64'(tag_q.size()));
            chk("err", 64'(err), 64'(m_err));
`ifdef RR_RSP_TIMEOUT_EN
            chk("timeout", 64'(timeout), 64'(m_to));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_vld = 1'b0;
        issue_gnt = '0;
        rsp_vld   = 1'b0;
        rsp_data  = '0;
        out_rdy   = '1;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        idle();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #12;
        chk("rst issue_rdy", 64'(issue_rdy), 64'd1);
        chk("rst out_vld", 64'(out_vld), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst outstanding", 64'(outstanding), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        cyc();
        rst_n = 1'b1;

        // In-order routing, one cycle accept-to-valid, back to back.
        issue_vld = 1; issue_gnt = 4'b0001;
        cyc();
        chk("t1 outstanding", 64'(outstanding), 64'd1);
        issue_gnt = 4'b0100; rsp_vld = 1; rsp_data = 32'hD000_0000;
        cyc();
        chk("t1 vld0", 64'(out_vld), 64'b0001);
        chk("t1 data0", 64'(out_data), 64'hD000_0000);
        issue_gnt = 4'b1000; rsp_data = 32'hD000_0001;
        cyc();
        chk("t1 vld1", 64'(out_vld), 64'b0100);
        chk("t1 data1", 64'(out_data), 64'hD000_0001);
        issue_vld = 0; issue_gnt = '0; rsp_data = 32'hD000_0002;
        cyc();
        chk("t1 vld2", 64'(out_vld), 64'b1000);
        chk("t1 data2", 64'(out_data), 64'hD000_0002);
        chk("t1 empty", 64'(outstanding), 64'd0);
        rsp_vld = 0;
        cyc();
        chk("t1 drained", 64'(out_vld), 64'd0);

        // Fill to DEPTH, overflow, then one accept frees a slot.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            issue_vld = 1; issue_gnt = 4'b0001 << (i % 4);
            cyc();
        end
        chk("t2 full rdy", 64'(issue_rdy), 64'd0);
        chk("t2 full occ", 64'(outstanding), 64'd8);
        chk("t2 no err yet", 64'(err), 64'd0);
        issue_gnt = 4'b0010;
        cyc();
        chk("t2 overflow err", 64'(err), 64'd1);
        chk("t2 occ held", 64'(outstanding), 64'd8);
        issue_vld = 0; rsp_vld = 1; rsp_data = 32'hA5A5_0000;
        cyc();
        chk("t2 rdy back", 64'(issue_rdy), 64'd1);
        chk("t2 first out", 64'(out_vld), 64'b0001);
        for (int i = 1; i < int'(DEPTH); i++) begin
            rsp_data = 32'hA5A5_0000 + 32'(i);
            cyc();
        end
        chk("t2 last out", 64'(out_vld), 64'b1000);
        chk("t2 last data", 64'(out_data), 64'hA5A5_0007);
        rsp_vld = 0;
        cyc();

        // Stall on requester 2, then drain and reload in one cycle.
        do_reset();
        issue_vld = 1; issue_gnt = 4'b0100;
        cyc();
        cyc();
        issue_vld = 0; issue_gnt = '0;
        out_rdy = 4'b1011; rsp_vld = 1; rsp_data = 32'h1111_2222;
        cyc();
        rsp_data = 32'h3333_4444;
        for (int i = 0; i < 5; i++) begin
            chk("t3 stall rsp_rdy", 64'(rsp_rdy), 64'd0);
            chk("t3 stall data", 64'(out_data), 64'h1111_2222);
            chk("t3 stall vld", 64'(out_vld), 64'b0100);
            cyc();
        end
        out_rdy = 4'b1111;
        #1;
        chk("t3 release rsp_rdy", 64'(rsp_rdy), 64'd1);
        cyc();
        chk("t3 reload vld", 64'(out_vld), 64'b0100);
        chk("t3 reload data", 64'(out_data), 64'h3333_4444);
        rsp_vld = 0;
        cyc();
        chk("t3 drained", 64'(out_vld), 64'd0);

        // Response with nothing outstanding.
        do_reset();
        rsp_vld = 1; rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("t4 rsp_rdy", 64'(rsp_rdy), 64'd0);
        cyc();
        chk("t4 err", 64'(err), 64'd1);
        chk("t4 out_vld", 64'(out_vld), 64'd0);
        rsp_vld = 0;
        cyc();

        // Asynchronous reset with tags in flight and the stage full.
        do_reset();
        issue_vld = 1;
        issue_gnt = 4'b0001; cyc();
        issue_gnt = 4'b0010; cyc();
        issue_gnt = 4'b0000; cyc();
        issue_gnt = 4'b1000; cyc();
        issue_gnt = 4'b0100; cyc();
        issue_vld = 0; issue_gnt = '0;
        out_rdy = '0; rsp_vld = 1; rsp_data = 32'h0BAD_F00D;
        cyc();
        rsp_vld = 0;
        chk("t5 pre occ", 64'(outstanding), 64'd4);
        chk("t5 pre vld", 64'(out_vld), 64'b0001);
        chk("t5 pre err", 64'(err), 64'd1);
        #1;
        rst_n = 0;
        #1;
        chk("t5 rst occ", 64'(outstanding), 64'd0);
        chk("t5 rst vld", 64'(out_vld), 64'd0);
        chk("t5 rst err", 64'(err), 64'd0);
        chk("t5 rst issue_rdy", 64'(issue_rdy), 64'd1);
        out_rdy = '1;
        cyc();
        rst_n = 1;
        cyc();

`ifdef RR_RSP_TIMEOUT_EN
        // Watchdog: a single tag with no response.
        do_reset();
        issue_vld = 1; issue_gnt = 4'b0001;
        cyc();
        issue_vld = 0; issue_gnt = '0;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk("t6 timeout", 64'(timeout), 64'(k >= 16));
            chk("t6 err", 64'(err), 64'(k >= 16));
        end
`endif

        cyc();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
